// File: rtl/key_schedule_seq_if.sv
// Start/status handshake and round-key read port of key_schedule_seq.
// master drives requests and read selects; slave is the key schedule itself.
interface key_schedule_seq_if #(
    parameter int SENTENCE = 128
);
    logic                start;
    logic [SENTENCE-1:0] cipher_Key;
    logic                busy;
    logic                done;
    logic                keys_Valid;
    logic [3:0]          rd_Round;
    logic [SENTENCE-1:0] rd_Key;

    modport master (
        output start, cipher_Key, rd_Round,
        input  busy, done, keys_Valid, rd_Key
    );

    modport slave (
        input  start, cipher_Key, rd_Round,
        output busy, done, keys_Valid, rd_Key
    );
endinterface

// File: rtl/key_schedule_seq.sv
// Sequential AES-128 key expansion: one round key per cycle into 11 readable slots.
// Define KEY_SCHED_RDREG_EN to register rd_Key (one cycle read latency).
module key_schedule_seq #(
    parameter int BYTE     = 8,
    parameter int WORD     = 32,
    parameter int SENTENCE = 128
) (
    input logic               clk,
    input logic               rst,
    key_schedule_seq_if.slave ks
);

    localparam int         NUM_SLOTS  = 11;
    localparam logic [3:0] LAST_ROUND = 4'd10;

    localparam logic [BYTE-1:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    function automatic logic [BYTE-1:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = '0;
        endcase
    endfunction

    function automatic logic [WORD-1:0] sub_word(input logic [WORD-1:0] w);
        logic [WORD-1:0] r;
        r = '0;
        for (int i = 0; i < WORD / BYTE; i++) begin
            r[i*BYTE +: BYTE] = SBOX[w[i*BYTE +: BYTE]];
        end
        return r;
    endfunction

    // Single AES-128 expansion round: four new words from the previous four.
    function automatic logic [SENTENCE-1:0] expand_round(input logic [SENTENCE-1:0] key,
                                                         input logic [3:0]          rnd);
        logic [WORD-1:0] w0, w1, w2, w3, t;
        w0 = key[SENTENCE-1 -: WORD];
        w1 = key[3*WORD-1 -: WORD];
        w2 = key[2*WORD-1 -: WORD];
        w3 = key[WORD-1:0];
        t  = sub_word({w3[WORD-BYTE-1:0], w3[WORD-1 -: BYTE]}) ^ {rcon(rnd), {(WORD-BYTE){1'b0}}};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_t              state_q, state_d;
    logic                load, step, last;
    logic [3:0]          round_q;
    logic [SENTENCE-1:0] work_q;
    logic [SENTENCE-1:0] next_key;
    logic [SENTENCE-1:0] slot_q [NUM_SLOTS];
    logic                done_q;
    logic                valid_q;
    logic [SENTENCE-1:0] rd_sel;

    assign next_key = expand_round(work_q, round_q);
    assign last     = (round_q == LAST_ROUND);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ks.start) begin
                    load    = 1'b1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                step = 1'b1;
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: slots are cleared on reset because rd_Key must read zero right after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            round_q <= '0;
            work_q  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                slot_q[0] <= ks.cipher_Key;
                work_q    <= ks.cipher_Key;
                round_q   <= 4'd1;
                valid_q   <= 1'b0;
            end else if (step) begin
                slot_q[round_q] <= next_key;
                work_q          <= next_key;
                round_q         <= last ? 4'd0 : round_q + 4'd1;
                if (last) begin
                    done_q  <= 1'b1;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        if (ks.rd_Round <= LAST_ROUND) rd_sel = slot_q[ks.rd_Round];
    end

`ifdef KEY_SCHED_RDREG_EN
    logic [SENTENCE-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (rst) rd_q <= '0;
        else     rd_q <= rd_sel;
    end

    assign ks.rd_Key = rd_q;
`else
    assign ks.rd_Key = rd_sel;
`endif

    assign ks.busy       = (state_q == EXPAND);
    assign ks.done       = done_q;
    assign ks.keys_Valid = valid_q;

endmodule

// File: doc/key_schedule_seq.md
KEY_SCHEDULE_SEQ -- requirements
Module: key_schedule_seq

Interface
REQ-001 Parameter BYTE, default 8, byte width in bits.
REQ-002 Parameter WORD, default 32, word width in bits.
REQ-003 Parameter SENTENCE, default 128, key/state width in bits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  request expansion of cipher_Key; sampled only in IDLE.
REQ-007 cipher_Key  input  SENTENCE  AES-128 cipher key; [127:96] is w0, [31:0] is w3.
REQ-008 busy  output  1  high while expansion is in progress.
REQ-009 done  output  1  one-cycle pulse when round key 10 has been stored.
REQ-010 keys_Valid  output  1  high while all 11 stored round keys belong to the last completed expansion.
REQ-011 rd_Round  input  4  read select for round key 0..10.
REQ-012 rd_Key  output  SENTENCE  round key selected by rd_Round.

Function
REQ-013 SHALL implement states IDLE and EXPAND; the current state is held in a register.
REQ-014 IDLE with start=1 at an edge: slot 0 <= cipher_Key, working key <= cipher_Key, round counter <= 1, keys_Valid <= 0, busy <= 1, state -> EXPAND.
REQ-015 EXPAND, each edge: next = one AES-128 expansion round of working key with Rcon(round counter), using the team's single-round expansion stage. Slot[counter] <= next, working key <= next, counter += 1.
REQ-016 The edge that writes slot 10 SHALL also set busy <= 0, done <= 1, keys_Valid <= 1 and state -> IDLE.
REQ-017 Latency: start sampled at edge k gives slot 0 at k, slots 1..10 at k+1..k+10, and done high during the cycle after k+10.
REQ-018 done SHALL be high for exactly one cycle per completed expansion.
REQ-019 start while busy SHALL be ignored, with no restart and no change to cipher_Key capture.
REQ-020 start in IDLE while keys_Valid=1 SHALL begin a new expansion and drop keys_Valid at the load edge.
REQ-021 rd_Round 0..10 SHALL return the stored slot. rd_Round 11..15 SHALL return all-zero.
REQ-022 rd_Key SHALL reflect slot contents at any time, including during busy; consumers qualify reads with keys_Valid.
REQ-023 The round counter SHALL be 4 bits wide and SHALL never exceed 10 in EXPAND.

Reset
REQ-024 rst=1 at an edge SHALL set: state IDLE, busy 0, done 0, keys_Valid 0, counter 0, working key 0, all 11 slots 0.
REQ-025 Reset SHALL take priority over start and over an in-progress expansion; an aborted expansion never produces done.
REQ-026 After reset, rd_Key SHALL read all-zero for every rd_Round.

Configuration
REQ-027 Macro KEY_SCHED_RDREG_EN, when defined: rd_Key SHALL be registered, showing the slot selected by rd_Round one cycle later, and SHALL reset to 0.
REQ-028 When KEY_SCHED_RDREG_EN is undefined: rd_Key SHALL be combinational from rd_Round and the slot contents, with zero latency.
REQ-029 All other timing SHALL be identical in both builds.

Verification
REQ-030 Start with cipher_Key=2b7e151628aed2a6abf7158809cf4f3c -> done exactly 11 cycles after the start edge. Round 1 reads a0fafe1788542cb123a339392a6c7605. Round 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6. keys_Valid=1.
REQ-031 cipher_Key=0 -> round 1 reads 62636363626363636263636362636363. Round 10 reads b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-032 Assert start again at cycle k+4 with a different key -> ignored; results match REQ-030 and there is a single done pulse.
REQ-033 Assert rst at cycle k+5 -> next cycle has busy=0, keys_Valid=0 and all slots zero; no done pulse follows.
REQ-034 rd_Round=11 and 15 -> rd_Key=0. With KEY_SCHED_RDREG_EN defined, the rd_Round change appears on rd_Key one cycle later.
REQ-035 Back-to-back expansions (start the cycle after done) -> keys_Valid falls at the load edge, rises with the second done, and the slots hold the second key's schedule.
